// File: rtl/vga_rx_pkg.sv
// Shared types and constants for the VGA receive-side sync decoder.
package vga_rx_pkg;

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } rx_state_e;

    // Nominal 640x480@60 timing.
    localparam int unsigned DEF_H_SYNC_CYC   = 96;
    localparam int unsigned DEF_H_SYNC_BACK  = 48;
    localparam int unsigned DEF_H_SYNC_ACT   = 640;
    localparam int unsigned DEF_H_SYNC_TOTAL = 800;
    localparam int unsigned DEF_V_SYNC_CYC   = 2;
    localparam int unsigned DEF_V_SYNC_BACK  = 33;
    localparam int unsigned DEF_V_SYNC_ACT   = 480;
    localparam int unsigned DEF_V_SYNC_TOTAL = 525;
    localparam int unsigned DEF_LOCK_FRAMES  = 2;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_crc16_24.sv
// One combinational CRC-16-CCITT step over a 24-bit word, MSB first.
module vga_crc16_24
    import vga_rx_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [23:0] data_i,
    output logic [15:0] crc_o
);
    always_comb begin
        logic fb;
        crc_o = crc_i;
        fb    = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            fb    = crc_o[15] ^ data_i[i];
            crc_o = {crc_o[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end
endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers coordinates, measures line/frame timing and tracks lock.
// Define VGA_FRAME_CRC_EN to build the per-frame CRC-16 over active pixels.
module vga_sync_decoder
    import vga_rx_pkg::*;
#(
    parameter int unsigned H_SYNC_CYC   = DEF_H_SYNC_CYC,
    parameter int unsigned H_SYNC_BACK  = DEF_H_SYNC_BACK,
    parameter int unsigned H_SYNC_ACT   = DEF_H_SYNC_ACT,
    parameter int unsigned H_SYNC_TOTAL = DEF_H_SYNC_TOTAL,
    parameter int unsigned V_SYNC_CYC   = DEF_V_SYNC_CYC,
    parameter int unsigned V_SYNC_BACK  = DEF_V_SYNC_BACK,
    parameter int unsigned V_SYNC_ACT   = DEF_V_SYNC_ACT,
    parameter int unsigned V_SYNC_TOTAL = DEF_V_SYNC_TOTAL,
    parameter int unsigned LOCK_FRAMES  = DEF_LOCK_FRAMES
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        iVGA_H_SYNC,
    input  logic        iVGA_V_SYNC,
    input  logic [9:0]  iVGA_R,
    input  logic [9:0]  iVGA_G,
    input  logic [9:0]  iVGA_B,
    output logic [9:0]  oCoord_X,
    output logic [9:0]  oCoord_Y,
    output logic        oPixel_Valid,
    output logic [9:0]  oRed,
    output logic [9:0]  oGreen,
    output logic [9:0]  oBlue,
    output logic        oFrame_Start,
    output logic        oLocked,
    output logic [9:0]  oLine_Len,
    output logic [7:0]  oErr_Count,
    output logic [15:0] oFrame_CRC
);
    localparam logic [10:0] H_START = 11'(H_SYNC_CYC + H_SYNC_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC_CYC + H_SYNC_BACK + H_SYNC_ACT);
    localparam logic [10:0] V_START = 11'(V_SYNC_CYC + V_SYNC_BACK);
    localparam logic [10:0] V_END   = 11'(V_SYNC_CYC + V_SYNC_BACK + V_SYNC_ACT);
    localparam logic [9:0]  H_OFS   = 10'(H_SYNC_CYC + H_SYNC_BACK);
    localparam logic [9:0]  V_OFS   = 10'(V_SYNC_CYC + V_SYNC_BACK);
    localparam logic [10:0] H_TOTAL = 11'(H_SYNC_TOTAL);
    localparam logic [10:0] V_TOTAL = 11'(V_SYNC_TOTAL);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    logic        hs_q, hs_dly_q, vs_q, vs_smp_q;
    logic [9:0]  r_q, g_q, b_q;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d, line_len, line_len_q;
    logic        hs_fall, vs_fall, line_bad, frame_ok, vs_missing, mismatch;
    logic        active, pix_on;
    rx_state_e   state_q, state_d;
    logic [3:0]  good_q, good_d;
    logic [7:0]  err_q, err_d;
    logic        pix_valid_q;
    logic [9:0]  x_q, y_q, red_q, green_q, blue_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hs_q     <= 1'b0;
            hs_dly_q <= 1'b0;
            vs_q     <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            hs_q     <= iVGA_H_SYNC;
            hs_dly_q <= hs_q;
            vs_q     <= iVGA_V_SYNC;
            r_q      <= iVGA_R;
            g_q      <= iVGA_G;
            b_q      <= iVGA_B;
        end
    end

    // The counters as seen in the current cycle; the _q copies hold the previous cycle.
    assign hs_fall  = hs_dly_q & ~hs_q;
    assign vs_fall  = hs_fall & vs_smp_q & ~vs_q;
    assign hcnt_d   = hs_fall ? 10'd0 : sat_inc10(hcnt_q);
    assign vcnt_d   = vs_fall ? 10'd0 : (hs_fall ? sat_inc10(vcnt_q) : vcnt_q);
    assign line_len = sat_inc10(hcnt_q);

    assign line_bad   = ({1'b0, line_len} != H_TOTAL);
    assign frame_ok   = (({1'b0, vcnt_q} + 11'd1) == V_TOTAL);
    assign vs_missing = ~vs_fall & frame_ok;
    assign mismatch   = hs_fall & (line_bad | (vs_fall & ~frame_ok) | vs_missing);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            vs_smp_q   <= 1'b0;
            line_len_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            if (hs_fall) begin
                vs_smp_q   <= vs_q;
                line_len_q <= line_len;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        err_d   = err_q;
        case (state_q)
            S_SEARCH: begin
                if (vs_fall) begin
                    state_d = S_MEASURE;
                    good_d  = 4'd0;
                end
            end
            S_MEASURE: begin
                if (mismatch) begin
                    state_d = S_SEARCH;
                end else if (vs_fall) begin
                    good_d = good_q + 4'd1;
                    if (good_d == LOCK_N) state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (mismatch) begin
                    state_d = S_SEARCH;
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_SEARCH;
            good_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    assign active = ({1'b0, hcnt_d} >= H_START) && ({1'b0, hcnt_d} < H_END) &&
                    ({1'b0, vcnt_d} >= V_START) && ({1'b0, vcnt_d} < V_END);
    assign pix_on = active & oLocked;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pix_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
        end else begin
            pix_valid_q <= pix_on;
            x_q         <= pix_on ? hcnt_d - H_OFS : 10'd0;
            y_q         <= pix_on ? vcnt_d - V_OFS : 10'd0;
            red_q       <= pix_on ? r_q : 10'd0;
            green_q     <= pix_on ? g_q : 10'd0;
            blue_q      <= pix_on ? b_q : 10'd0;
        end
    end

    assign oPixel_Valid = pix_valid_q;
    assign oCoord_X     = x_q;
    assign oCoord_Y     = y_q;
    assign oRed         = red_q;
    assign oGreen       = green_q;
    assign oBlue        = blue_q;
    assign oFrame_Start = vs_fall;
    assign oLocked      = (state_q == S_LOCKED);
    assign oLine_Len    = line_len_q;
    assign oErr_Count   = err_q;

`ifdef VGA_FRAME_CRC_EN
    logic [15:0] crc_q, crc_step, frame_crc_q;

    vga_crc16_24 u_crc (
        .crc_i  (crc_q),
        .data_i ({red_q[9:2], green_q[9:2], blue_q[9:2]}),
        .crc_o  (crc_step)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            crc_q       <= CRC16_INIT;
            frame_crc_q <= '0;
        end else if (vs_fall) begin
            frame_crc_q <= crc_q;
            crc_q       <= CRC16_INIT;
        end else if (pix_valid_q) begin
            crc_q <= crc_step;
        end
    end

    assign oFrame_CRC = frame_crc_q;
`else
    assign oFrame_CRC = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed frame-level bench for vga_sync_decoder using a shrunken raster (20x10 clocks per frame).
module tb_vga_sync_decoder;
    localparam int HC = 4, HB = 3, HA = 8, HT = 20;
    localparam int VC = 2, VB = 2, VA = 4, VT = 10;
    localparam int HS = HC + HB, VS = VC + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_in, vs_in;
    logic [9:0]  r_in, g_in, b_in;
    logic [9:0]  oCoord_X, oCoord_Y, oRed, oGreen, oBlue, oLine_Len;
    logic        oPixel_Valid, oFrame_Start, oLocked;
    logic [7:0]  oErr_Count;
    logic [15:0] oFrame_CRC;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_SYNC_CYC(HC), .H_SYNC_BACK(HB), .H_SYNC_ACT(HA), .H_SYNC_TOTAL(HT),
        .V_SYNC_CYC(VC), .V_SYNC_BACK(VB), .V_SYNC_ACT(VA), .V_SYNC_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .Clock(clk), .Reset(rst),
        .iVGA_H_SYNC(hs_in), .iVGA_V_SYNC(vs_in),
        .iVGA_R(r_in), .iVGA_G(g_in), .iVGA_B(b_in),
        .oCoord_X(oCoord_X), .oCoord_Y(oCoord_Y), .oPixel_Valid(oPixel_Valid),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oFrame_Start(oFrame_Start), .oLocked(oLocked), .oLine_Len(oLine_Len),
        .oErr_Count(oErr_Count), .oFrame_CRC(oFrame_CRC)
    );

    typedef struct {
        int stretch;    // line index made one clock longer, -1 for none
        bit vs_off;     // hold vsync high for the whole frame
        bit rst_mid;    // pulse reset at line 5, clock 10
        bit corner;     // run the frame-start / first-pixel spot checks
        int exp_lock;
        int exp_err;
        int exp_valid;
        int exp_fs;
        int crc_kind;   // 0 skip, 1 full-frame CRC, 2 init value, 3 zero
    } frame_vec_t;

    frame_vec_t  vecs[16];
    int          n_cmp = 0, n_bad = 0;
    int          valid_cnt, pix_bad, fs_cnt;
    bit          prev_act = 1'b0;
    int          prev_x = 0, prev_y = 0;
    logic [15:0] crc_full;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // One pixel clock of the reference raster, then sample the decoder outputs.
    task automatic drive(input int h, input int v, input bit vs_off);
        bit act;
        act   = (h >= HS) && (h < HS + HA) && (v >= VS) && (v < VS + VA);
        hs_in = (h >= HC);
        vs_in = vs_off || (v >= VC);
        r_in  = act ? 10'(h - HS) : 10'h3FF;
        g_in  = act ? 10'(v - VS) : 10'h2AA;
        b_in  = act ? 10'd0 : 10'h155;
        @(posedge clk);
        #1;
        if (oPixel_Valid) begin
            valid_cnt++;
            if (!prev_act || oCoord_X != 10'(prev_x) || oCoord_Y != 10'(prev_y) ||
                oRed != 10'(prev_x) || oGreen != 10'(prev_y) || oBlue != 10'd0)
                pix_bad++;
        end else if (oRed != 10'd0 || oGreen != 10'd0 || oBlue != 10'd0) begin
            pix_bad++;
        end
        if (oFrame_Start) fs_cnt++;
        prev_act = act;
        prev_x   = h - HS;
        prev_y   = v - VS;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(oPixel_Valid), 0);
        check({tag, "_locked"}, int'(oLocked), 0);
        check({tag, "_fstart"}, int'(oFrame_Start), 0);
        check({tag, "_linelen"}, int'(oLine_Len), 0);
        check({tag, "_errcnt"}, int'(oErr_Count), 0);
        check({tag, "_xy"}, int'(oCoord_X) + int'(oCoord_Y), 0);
        check({tag, "_rgb"}, int'(oRed) + int'(oGreen) + int'(oBlue), 0);
        check({tag, "_crc"}, int'(oFrame_CRC), 0);
    endtask

    task automatic reset_pulse();
        #1 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        #1 rst = 1'b0;
    endtask

    task automatic run_frame(input int v_start, input int stretch, input bit vs_off,
                             input bit rst_mid, input bit corner, input int exp_err);
        for (int v = v_start; v < VT; v++) begin
            int len;
            len = (v == stretch) ? HT + 1 : HT;
            for (int h = 0; h < len; h++) begin
                if (rst_mid && v == 5 && h == 10) reset_pulse();
                drive(h, v, vs_off);
                if (stretch >= 0 && v == stretch + 1 && h == 0)
                    check("stretch_lock_held", int'(oLocked), 1);
                if (stretch >= 0 && v == stretch + 1 && h == 1) begin
                    check("stretch_lock_drop", int'(oLocked), 0);
                    check("stretch_line_len", int'(oLine_Len), HT + 1);
                    check("stretch_err_count", int'(oErr_Count), exp_err);
                end
                if (corner && v == 0 && h == 0) check("fstart_pulse", int'(oFrame_Start), 1);
                if (corner && v == 0 && h == 1) check("fstart_single", int'(oFrame_Start), 0);
                if (corner && v == VS && h == HS + 1) begin
                    check("first_pix_valid", int'(oPixel_Valid), 1);
                    check("first_pix_x", int'(oCoord_X), 0);
                    check("first_pix_y", int'(oCoord_Y), 0);
                end
            end
        end
    endtask

    initial begin
        //            stretch vs_off rst  corner lock err valid fs crc
        vecs[0]  = '{-1, 1'b0, 1'b0, 1'b0, 0, 0,  0, 1, 0};
        vecs[1]  = '{-1, 1'b0, 1'b0, 1'b0, 0, 0,  0, 1, 2};
        vecs[2]  = '{-1, 1'b0, 1'b0, 1'b0, 1, 0, 32, 1, 2};
        vecs[3]  = '{-1, 1'b0, 1'b0, 1'b1, 1, 0, 32, 1, 1};
        vecs[4]  = '{ 6, 1'b0, 1'b0, 1'b0, 0, 1, 24, 1, 1};
        vecs[5]  = '{-1, 1'b0, 1'b0, 1'b0, 0, 1,  0, 1, 0};
        vecs[6]  = '{-1, 1'b0, 1'b0, 1'b0, 0, 1,  0, 1, 2};
        vecs[7]  = '{-1, 1'b0, 1'b0, 1'b0, 1, 1, 32, 1, 2};
        vecs[8]  = '{-1, 1'b1, 1'b0, 1'b0, 0, 2,  0, 0, 2};
        vecs[9]  = '{-1, 1'b0, 1'b0, 1'b0, 0, 2,  0, 1, 1};
        vecs[10] = '{-1, 1'b0, 1'b0, 1'b0, 0, 2,  0, 1, 2};
        vecs[11] = '{-1, 1'b0, 1'b0, 1'b1, 1, 2, 32, 1, 2};
        vecs[12] = '{-1, 1'b0, 1'b1, 1'b0, 0, 0, 10, 1, 3};
        vecs[13] = '{-1, 1'b0, 1'b0, 1'b0, 0, 0,  0, 1, 2};
        vecs[14] = '{-1, 1'b0, 1'b0, 1'b0, 0, 0,  0, 1, 2};
        vecs[15] = '{-1, 1'b0, 1'b0, 1'b0, 1, 0, 32, 1, 2};

        crc_full = 16'hFFFF;
        for (int y = 0; y < VA; y++) begin
            for (int x = 0; x < HA; x++) begin
                logic [9:0] xv, yv;
                xv = 10'(x);
                yv = 10'(y);
                crc_full = crc_word(crc_full, {xv[9:2], yv[9:2], 8'h00});
            end
        end

        hs_in = 1'b1;
        vs_in = 1'b1;
        r_in  = '0;
        g_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Start mid-frame so the first vs_fall comes from a clean sampled edge.
        valid_cnt = 0; pix_bad = 0; fs_cnt = 0;
        run_frame(5, -1, 1'b0, 1'b0, 1'b0, 0);
        check("partial_valid", valid_cnt, 0);

        for (int i = 0; i < 16; i++) begin
            valid_cnt = 0; pix_bad = 0; fs_cnt = 0;
            run_frame(0, vecs[i].stretch, vecs[i].vs_off, vecs[i].rst_mid,
                      vecs[i].corner, vecs[i].exp_err);
            check($sformatf("f%0d_locked", i), int'(oLocked), vecs[i].exp_lock);
            check($sformatf("f%0d_err_count", i), int'(oErr_Count), vecs[i].exp_err);
            check($sformatf("f%0d_valid_count", i), valid_cnt, vecs[i].exp_valid);
            check($sformatf("f%0d_frame_starts", i), fs_cnt, vecs[i].exp_fs);
            check($sformatf("f%0d_pixel_errors", i), pix_bad, 0);
            check($sformatf("f%0d_line_len", i), int'(oLine_Len), HT);
`ifdef VGA_FRAME_CRC_EN
            if (vecs[i].crc_kind == 1)
                check($sformatf("f%0d_crc_full", i), int'(oFrame_CRC), int'(crc_full));
            else if (vecs[i].crc_kind == 2)
                check($sformatf("f%0d_crc_init", i), int'(oFrame_CRC), 16'hFFFF);
            else if (vecs[i].crc_kind == 3)
                check($sformatf("f%0d_crc_zero", i), int'(oFrame_CRC), 0);
`else
            check($sformatf("f%0d_crc_off", i), int'(oFrame_CRC), 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
